// File: rtl/ascii_seq_gen.sv
// ascii_seq_gen
//   Generates a repeating sweep of characters in [FIRST, LAST] for a UART
//   transmitter, one character per start/busy handshake, with GAP idle clocks
//   between characters and an optional CR/LF after each sweep.
//
// Parameters
//   SIZE   word width
//   FIRST  lower bound of the character range
//   LAST   upper bound of the character range (FIRST <= LAST)
//   MODE   0 ascending, 1 descending, 2 ping-pong
//   GAP    idle clocks after each character
//   EOL    1 appends CR, LF after every sweep
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      keep generating characters while high
//   tx_busy     transmitter busy flag
//   start       one-cycle transmit request
//   word        character being sent; held until tx_busy falls
//   sweep_done  one-cycle pulse after the last character of a sweep
module ascii_seq_gen #(
    parameter int              SIZE  = 8,
    parameter logic [SIZE-1:0] FIRST = 8'd97,
    parameter logic [SIZE-1:0] LAST  = 8'd122,
    parameter int              MODE  = 0,
    parameter int              GAP   = 16,
    parameter int              EOL   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            tx_busy,
    output logic            start,
    output logic [SIZE-1:0] word,
    output logic            sweep_done
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [SIZE-1:0] CHAR_CR = SIZE'(13);
    localparam logic [SIZE-1:0] CHAR_LF = SIZE'(10);
    localparam logic [SIZE-1:0] RST_POS = (MODE == 1) ? LAST : FIRST;

    // What the current word is: a range character, or the CR/LF trailer
    localparam logic [1:0] PH_CHAR = 2'd0;
    localparam logic [1:0] PH_CR   = 2'd1;
    localparam logic [1:0] PH_LF   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_TX,
        S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   gap_cnt;
    logic [SIZE-1:0] pos, pos_nxt;
    logic            dir_up, dir_nxt;
    logic [1:0]      phase, phase_nxt;
    logic            range_end;
    logic            last_of_sweep;
    logic            tx_done;

    assign tx_done = (state == S_WAIT_TX) && !tx_busy;

    // Next range position. range_end marks the character that closes a sweep.
    always_comb begin
        pos_nxt   = pos;
        dir_nxt   = dir_up;
        range_end = 1'b0;
        case (MODE)
            1: begin
                range_end = (pos == FIRST);
                pos_nxt   = range_end ? LAST : pos - SIZE'(1);
            end
            2: begin
                if (dir_up) begin
                    if (pos == LAST) begin
                        range_end = 1'b1;
                        dir_nxt   = 1'b0;
                        // single-character range must not step outside itself
                        pos_nxt   = (LAST == FIRST) ? pos : pos - SIZE'(1);
                    end else begin
                        pos_nxt = pos + SIZE'(1);
                    end
                end else begin
                    if (pos == FIRST) begin
                        range_end = 1'b1;
                        dir_nxt   = 1'b1;
                        pos_nxt   = (LAST == FIRST) ? pos : pos + SIZE'(1);
                    end else begin
                        pos_nxt = pos - SIZE'(1);
                    end
                end
            end
            default: begin
                range_end = (pos == LAST);
                pos_nxt   = range_end ? FIRST : pos + SIZE'(1);
            end
        endcase
    end

    // Trailer sequencing: endpoint -> CR -> LF -> next range char
    always_comb begin
        phase_nxt     = PH_CHAR;
        last_of_sweep = 1'b0;
        case (phase)
            PH_CHAR: begin
                if (range_end) begin
                    if (EOL != 0) phase_nxt = PH_CR;
                    else          last_of_sweep = 1'b1;
                end
            end
            PH_CR:   phase_nxt = PH_LF;
            default: begin
                phase_nxt     = PH_CHAR;
                last_of_sweep = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. A pending CR/LF keeps the FSM sending even when
    // enable has dropped, so a line is never left unterminated.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (enable) state_nxt = S_SEND;
            S_SEND:     state_nxt = tx_busy ? S_WAIT_TX : S_WAIT_ACK;
            S_WAIT_ACK: if (tx_busy) state_nxt = S_WAIT_TX;
            S_WAIT_TX: begin
                if (!tx_busy) begin
                    if (GAP > 0)
                        state_nxt = S_GAP;
                    else
                        state_nxt = (enable || phase_nxt != PH_CHAR) ? S_SEND : S_IDLE;
                end
            end
            S_GAP: begin
                // counter reaches zero on the edge that leaves GAP
                if (gap_cnt <= GW'(1))
                    state_nxt = (enable || phase != PH_CHAR) ? S_SEND : S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        start = (state == S_SEND);
        case (phase)
            PH_CR:   word = CHAR_CR;
            PH_LF:   word = CHAR_LF;
            default: word = pos;
        endcase
    end

    // Sequence position, gap counter and sweep pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt    <= '0;
            pos        <= RST_POS;
            dir_up     <= 1'b1;
            phase      <= PH_CHAR;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (tx_done) begin
                gap_cnt    <= GW'(GAP);
                phase      <= phase_nxt;
                sweep_done <= last_of_sweep;
                if (phase == PH_CHAR) begin
                    pos    <= pos_nxt;
                    dir_up <= dir_nxt;
                end
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

endmodule

// File: doc/ascii_seq_gen.md
ASCII_SEQ_GEN -- requirements
Module: ascii_seq_gen

Interface
REQ-001 Parameter SIZE, default 8, word width in bits.
REQ-002 Parameter FIRST, default 8'd97 ('a'), lower bound of the character range.
REQ-003 Parameter LAST, default 8'd122 ('z'), upper bound of the range; FIRST <= LAST.
REQ-004 Parameter MODE, default 0, sweep mode: 0 ascending, 1 descending, 2 ping-pong.
REQ-005 Parameter GAP, default 16, idle clocks inserted after each character completes.
REQ-006 Parameter EOL, default 1: 1 appends CR (8'd13) then LF (8'd10) after each sweep; 0 appends nothing.
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 enable  input  1  high = generate characters continuously.
REQ-010 tx_busy  input  1  UART transmitter busy flag.
REQ-011 start  output  1  one-cycle pulse requesting transmission of word.
REQ-012 word  output  SIZE  character presented to the transmitter; stable from start until tx_busy falls.
REQ-013 sweep_done  output  1  one-cycle pulse at the end of each sweep.

Function
REQ-014 FSM states: IDLE, SEND, WAIT_ACK, WAIT_TX, GAP.
REQ-015 IDLE: start=0; if enable=1, go to SEND on the next edge.
REQ-016 SEND: start=1 for exactly one cycle; go to WAIT_ACK.
REQ-017 WAIT_ACK: hold until tx_busy=1, then go to WAIT_TX; a tx_busy already high in SEND counts as the acknowledge.
REQ-018 WAIT_TX: hold until tx_busy=0, then load the gap counter with GAP and go to GAP; word advances on this same edge.
REQ-019 GAP: decrement each cycle; at 0 go to SEND if enable=1, else IDLE; GAP=0 goes straight from WAIT_TX to SEND/IDLE.
REQ-020 Ascending: FIRST..LAST, then wraps to FIRST.
REQ-021 Descending: LAST..FIRST, then wraps to LAST.
REQ-022 Ping-pong: FIRST..LAST..FIRST; each endpoint is sent once per turn and the direction flips at that endpoint.
REQ-023 A sweep ends after the wrap endpoint is sent: LAST in mode 0, FIRST in mode 1, either endpoint in mode 2.
REQ-024 EOL=1: after a sweep ends, send CR then LF through the same handshake before the next range character.
REQ-025 sweep_done pulses for one cycle on the WAIT_TX exit of the last character of a sweep (LF if EOL=1, otherwise the endpoint).
REQ-026 FIRST==LAST: the same character repeats; every character is a complete sweep.
REQ-027 Word arithmetic is SIZE-bit unsigned; the next value never leaves [FIRST, LAST] except for CR/LF.
REQ-028 enable falling mid-character: the current character and any pending CR/LF finish, then the FSM goes to IDLE; sequence position and direction are retained.
REQ-029 enable rising in IDLE: resume from the retained position.

Reset
REQ-030 rst_n=0 asynchronously forces state=IDLE, start=0, sweep_done=0, gap counter=0 and direction=up.
REQ-031 Reset word value: FIRST for MODE 0/2, LAST for MODE 1.
REQ-032 Reset mid-transmission abandons the handshake; after rst_n releases, the first start carries the reset word value.

Verification
REQ-033 MODE=0, EOL=0, GAP=2; transmitter model holds busy 10 clocks -> start carries 97..122, then 97; sweep_done pulses after 122; 12 clocks between starts after the first.
REQ-034 MODE=2, FIRST=65, LAST=67, EOL=0 -> word sequence 65,66,67,66,65,66; sweep_done after 67 and after 65.
REQ-035 MODE=1, EOL=1 -> sequence 122..97,13,10,122; sweep_done after 10 only.
REQ-036 enable dropped during 'c' WAIT_TX -> 'c' completes, FSM goes IDLE with no further start; re-enable -> next start carries 'd'.
REQ-037 rst_n pulsed low while in WAIT_TX at 'k' -> start=0 immediately; first start after release carries 97.
REQ-038 tx_busy held high for 50 clocks after start -> no second start until 1 clock after busy falls plus GAP clocks; word stable throughout.
